// File: rtl/as5600_i2c_target_pkg.sv
// Shared types and constants for the AS5600-compatible I2C read target.
package i2c_tgt_pkg;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, TX, TX_ACKCHK, WAIT_STOP
  } state_e;

  localparam logic [7:0] STATUS      = 8'h0B;
  localparam logic [7:0] RAW_ANGLE_H = 8'h0C;
  localparam logic [7:0] RAW_ANGLE_L = 8'h0D;
  localparam logic [7:0] ANGLE_H     = 8'h0E;
  localparam logic [7:0] ANGLE_L     = 8'h0F;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h36;

  function automatic logic [7:0] reg_read(input logic [7:0] ptr,
                                          input logic [11:0] angle,
                                          input logic [2:0] status);
    logic [7:0] val;
    case (ptr)
      STATUS:               val = {2'b00, status, 3'b000};
      RAW_ANGLE_H, ANGLE_H: val = {4'h0, angle[11:8]};
      RAW_ANGLE_L, ANGLE_L: val = angle[7:0];
      default:              val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/as5600_i2c_target_if.sv
// Angle/status side of the target: value to serve in, transaction status out.
interface as5600_i2c_target_if;
  logic [11:0] raw_angle;
  logic [2:0]  magnet_status;
  logic        busy;
  logic        xfer_done;
  logic [7:0]  reg_ptr;

  modport slave  (input raw_angle, magnet_status, output busy, xfer_done, reg_ptr);
  modport master (output raw_angle, magnet_status, input busy, xfer_done, reg_ptr);
endinterface

// File: rtl/as5600_i2c_target_bus_sync.sv
// scl/sda synchronizers, edge and START/STOP detection.
// Optional 3-sample majority filter enabled by I2C_TGT_GLITCH_FILTER_EN.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic sda_s_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_c, sda_c, scl_prev_q, sda_prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_flt_q, sda_flt_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[SYNC_STAGES-1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[SYNC_STAGES-1]};
      scl_flt_q  <= maj3(scl_sync_q[SYNC_STAGES-1], scl_hist_q[0], scl_hist_q[1]);
      sda_flt_q  <= maj3(sda_sync_q[SYNC_STAGES-1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_c = scl_flt_q;
  assign sda_c = sda_flt_q;
`else
  assign scl_c = scl_sync_q[SYNC_STAGES-1];
  assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_c;
      sda_prev_q <= sda_c;
    end
  end

  assign scl_rise_o  = scl_c & ~scl_prev_q;
  assign scl_fall_o  = ~scl_c & scl_prev_q;
  assign sda_s_o     = sda_c;
  assign start_det_o = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det_o  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

endmodule

// File: rtl/as5600_i2c_target.sv
// AS5600-style read-only I2C target serving a 12-bit angle with per-read snapshot.
// Build option: I2C_TGT_GLITCH_FILTER_EN (majority filter in i2c_bus_sync).
//   state      | meaning
//   IDLE       | bus free, waiting for START
//   ADDR       | shifting address byte
//   ADDR_ACK   | address matched, driving ACK
//   PTR        | shifting register pointer
//   PTR_ACK    | ACKing pointer byte
//   WDATA      | shifting (discarded) write data
//   WDATA_ACK  | ACKing write data byte
//   TX         | shifting register byte out
//   TX_ACKCHK  | sampling initiator ACK/NACK
//   WAIT_STOP  | ignoring bus until STOP/START
module as5600_i2c_target
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       scl_i,
  inout  wire                        sda_io,
  as5600_i2c_target_if.slave         ang_if
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .scl_i      (scl_i),
    .sda_i      (sda_io),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .sda_s_o    (sda_s),
    .start_det_o(start_det),
    .stop_det_o (stop_det)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  sh_q, sh_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        oe_q, oe_d, busy_q, busy_d, done_q, done_d, rw_q, rw_d;
  logic [11:0] shadow_angle_q, shadow_angle_d;
  logic [2:0]  shadow_status_q, shadow_status_d;
  logic        fall_d1_q;
  logic [7:0]  shift_in, tx_byte;

  assign shift_in = {sh_q, sda_s};
  assign tx_byte  = reg_read(ptr_q, shadow_angle_q, shadow_status_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      sh_q            <= '0;
      ptr_q           <= '0;
      oe_q            <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      rw_q            <= 1'b0;
      shadow_angle_q  <= '0;
      shadow_status_q <= '0;
      fall_d1_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      sh_q            <= sh_d;
      ptr_q           <= ptr_d;
      oe_q            <= oe_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      rw_q            <= rw_d;
      shadow_angle_q  <= shadow_angle_d;
      shadow_status_q <= shadow_status_d;
      fall_d1_q       <= scl_fall;
    end
  end

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    sh_d            = sh_q;
    ptr_d           = ptr_q;
    oe_d            = oe_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    rw_d            = rw_q;
    shadow_angle_d  = shadow_angle_q;
    shadow_status_d = shadow_status_q;

    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = busy_q;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
    end else begin
      // Drive updates trail the synced SCL fall by one clock for hold time.
      if (fall_d1_q) begin
        case (state_q)
          ADDR_ACK, PTR_ACK, WDATA_ACK: oe_d = 1'b1;
          TX:                           oe_d = ~tx_byte[~bit_cnt_q];
          default:                      oe_d = 1'b0;
        endcase
      end
      if (scl_rise) begin
        case (state_q)
          ADDR: begin
            sh_d      = shift_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (shift_in[7:1] == DEV_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = shift_in[0];
                if (shift_in[0]) begin
                  shadow_angle_d  = ang_if.raw_angle;
                  shadow_status_d = ang_if.magnet_status;
                end
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end
          ADDR_ACK: state_d = rw_q ? TX : PTR;
          PTR: begin
            sh_d      = shift_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d   = shift_in;
              state_d = PTR_ACK;
            end
          end
          PTR_ACK:   state_d = WDATA;
          WDATA: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d   = ptr_q + 8'd1;
              state_d = WDATA_ACK;
            end
          end
          WDATA_ACK: state_d = WDATA;
          TX: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = TX_ACKCHK;
          end
          // Pointer advances past every byte sent, including the NACKed last one.
          TX_ACKCHK: begin
            ptr_d   = ptr_q + 8'd1;
            state_d = sda_s ? WAIT_STOP : TX;
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_io           = oe_q ? 1'b0 : 1'bz;
  assign ang_if.busy      = busy_q;
  assign ang_if.xfer_done = done_q;
  assign ang_if.reg_ptr   = ptr_q;

endmodule

// File: tb/tb_as5600_i2c_target.sv
// Bench for as5600_i2c_target: bit-banged initiator, randomized reads vs. a register-map model.
module tb_as5600_i2c_target;

  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_low = 1'b0;
  wire  sda;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  as5600_i2c_target_if ang_if();

  as5600_i2c_target dut (
    .clk_i (clk),
    .rst_i (rst),
    .scl_i (scl),
    .sda_io(sda),
    .ang_if(ang_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  always @(posedge clk) if (ang_if.xfer_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference register map as the initiator sees it.
  function automatic logic [7:0] model_byte(input logic [7:0] p, input logic [11:0] a,
                                            input logic [2:0] s);
    logic [7:0] m [256];
    foreach (m[i]) m[i] = 8'h00;
    m[8'h0B] = {2'b00, s, 3'b000};
    m[8'h0C] = {4'h0, a[11:8]};
    m[8'h0E] = {4'h0, a[11:8]};
    m[8'h0D] = a[7:0];
    m[8'h0F] = a[7:0];
    return m[p];
  endfunction

  task automatic i2c_start();
    sda_low = 1'b0; clks(Q);
    scl = 1'b1;     clks(Q);
    sda_low = 1'b1; clks(Q);
    scl = 1'b0;     clks(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; clks(Q);
    scl = 1'b1;     clks(Q);
    sda_low = 1'b0; clks(Q);
  endtask

  task automatic wr_bit(input logic b);
    sda_low = ~b; clks(Q);
    scl = 1'b1;   clks(2*Q);
    scl = 1'b0;   clks(Q);
  endtask

  task automatic rd_bit(output logic b);
    sda_low = 1'b0; clks(Q);
    scl = 1'b1;     clks(Q);
    b = sda;        clks(Q);
    scl = 1'b0;     clks(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(ack);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(nack);
  endtask

  // Full pointer-write then repeated-start read of n bytes.
  task automatic xact(input string tag, input logic [7:0] ptr, input int n);
    logic a;
    logic [7:0] d;
    int d0;
    logic [11:0] ang;
    logic [2:0] st;
    d0 = done_cnt;
    i2c_start();
    wr_byte({7'h36, 1'b0}, a);
    chk($sformatf("%s_aack_w", tag), a, 0);
    chk($sformatf("%s_busy", tag), ang_if.busy, 1);
    wr_byte(ptr, a);
    chk($sformatf("%s_pack", tag), a, 0);
    i2c_start();
    ang = ang_if.raw_angle;
    st  = ang_if.magnet_status;
    wr_byte({7'h36, 1'b1}, a);
    chk($sformatf("%s_aack_r", tag), a, 0);
    for (int i = 0; i < n; i++) begin
      rd_byte(d, (i == n - 1));
      chk($sformatf("%s_byte%0d", tag, i), d, model_byte(8'(ptr + i), ang, st));
    end
    i2c_stop();
    clks(4);
    chk($sformatf("%s_busy_end", tag), ang_if.busy, 0);
    chk($sformatf("%s_done", tag), done_cnt - d0, 1);
    chk($sformatf("%s_ptr_end", tag), ang_if.reg_ptr, 8'(ptr + n));
  endtask

`ifdef I2C_TGT_GLITCH_FILTER_EN
  task automatic wr_bit_glitch(input logic b);
    sda_low = ~b; clks(Q);
    scl = 1'b1;   clks(Q);
    scl = 1'b0;   clks(1);
    scl = 1'b1;   clks(Q);
    scl = 1'b0;   clks(Q);
  endtask
`endif

  initial begin
    logic a;
    logic [7:0] d;
    int d0;
    logic [7:0] p;
    int n;

    ang_if.raw_angle = 12'h000;
    ang_if.magnet_status = 3'b000;
    clks(4);
    rst = 1'b0;
    clks(4);
    chk("rst_busy", ang_if.busy, 0);
    chk("rst_done", ang_if.xfer_done, 0);
    chk("rst_ptr", ang_if.reg_ptr, 0);
    chk("rst_sda", sda, 1);

    ang_if.raw_angle = 12'hABC;
    xact("basic", 8'h0C, 2);

    // Address mismatch
    d0 = done_cnt;
    i2c_start();
    wr_byte({7'h37, 1'b0}, a);
    chk("mis_nack", a, 1);
    chk("mis_busy", ang_if.busy, 0);
    i2c_stop();
    clks(4);
    chk("mis_done", done_cnt - d0, 0);

    // Snapshot holds across a changing angle
    ang_if.raw_angle = 12'h123;
    i2c_start();
    wr_byte({7'h36, 1'b0}, a);
    wr_byte(8'h0C, a);
    i2c_start();
    wr_byte({7'h36, 1'b1}, a);
    rd_byte(d, 1'b0);
    chk("snap_b0", d, 8'h01);
    ang_if.raw_angle = 12'h456;
    rd_byte(d, 1'b1);
    chk("snap_b1", d, 8'h23);
    i2c_stop();
    i2c_start();
    wr_byte({7'h36, 1'b1}, a);
    chk("snap2_ack", a, 0);
    rd_byte(d, 1'b0);
    chk("snap2_b0", d, 8'h04);
    rd_byte(d, 1'b1);
    chk("snap2_b1", d, 8'h56);
    i2c_stop();

    xact("wrap", 8'hFF, 2);

    ang_if.magnet_status = 3'b100;
    xact("status", 8'h0B, 1);

    for (int k = 0; k < 8; k++) begin
      ang_if.raw_angle = 12'($urandom);
      ang_if.magnet_status = 3'($urandom);
      case ($urandom_range(0, 3))
        0: p = 8'h0B + 8'($urandom_range(0, 4));
        1: p = 8'hFE + 8'($urandom_range(0, 1));
        default: p = 8'($urandom);
      endcase
      n = $urandom_range(1, 3);
      xact($sformatf("rnd%0d", k), p, n);
    end

    // Reset while the target drives a 0 data bit
    ang_if.raw_angle = 12'hABC;
    i2c_start();
    wr_byte({7'h36, 1'b0}, a);
    wr_byte(8'h0C, a);
    i2c_start();
    wr_byte({7'h36, 1'b1}, a);
    chk("rst_mid_low", sda, 0);
    rst = 1'b1;
    clks(1);
    chk("rst_mid_rel", sda, 1);
    rst = 1'b0;
    chk("rst_mid_busy", ang_if.busy, 0);
    chk("rst_mid_ptr", ang_if.reg_ptr, 0);
    i2c_stop();
    ang_if.raw_angle = 12'h7E5;
    xact("post_rst", 8'h0C, 2);

`ifdef I2C_TGT_GLITCH_FILTER_EN
    ang_if.raw_angle = 12'h9D3;
    i2c_start();
    wr_byte({7'h36, 1'b0}, a);
    for (int i = 7; i >= 0; i--) begin
      p = 8'h0D;
      if (i == 4) wr_bit_glitch(p[i]);
      else wr_bit(p[i]);
    end
    rd_bit(a);
    chk("glitch_pack", a, 0);
    i2c_start();
    wr_byte({7'h36, 1'b1}, a);
    rd_byte(d, 1'b1);
    chk("glitch_byte", d, 8'hD3);
    i2c_stop();
`endif

    clks(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
